// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common command bytes and frame helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RELEASE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam int         PS2_FRAME_EDGES  = 11;

  // Bits shifted after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a falling-edge strobe on clock.
module ps2_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false fall.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign fall      = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte, check device ack.
// tx_valid/tx_ready: a byte is taken on a cycle where both are high; tx_valid while busy is dropped.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000) * 15
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  output ps2_state_e state_dbg
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(TMR_MAX);
  localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] WD_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_SHIFT = 4'(PS2_FRAME_EDGES - 2);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    edge_q, edge_d;
  logic [9:0]    frame_q, frame_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          err_q, err_d;
  logic          ack_seen_q, ack_seen_d;
  logic          wd_expire;
  logic          clk_sync, data_sync, fall;

  ps2_line_sync u_sync (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      edge_q     <= '0;
      frame_q    <= '0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      edge_q     <= edge_d;
      frame_q    <= frame_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      err_q      <= err_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    edge_d     = edge_q;
    frame_d    = frame_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    err_d      = err_q;
    ack_seen_d = ack_seen_q;
    wd_expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          frame_d = ps2_frame(tx_data);
          edge_d  = '0;
          tmr_d   = INH_LOAD;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        // Falls here are our own clock hold and are deliberately not counted.
        if (tmr_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      REQ: begin
        tmr_d   = WD_LOAD;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          edge_d    = edge_q + 1'b1;
          tmr_d     = WD_LOAD;
          data_oe_d = ~frame_q[edge_q];
          if (edge_q == LAST_SHIFT) state_d = ACK;
        end else if (tmr_q == '0) begin
          wd_expire = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          edge_d     = edge_q + 1'b1;
          tmr_d      = WD_LOAD;
          ack_seen_d = ~data_sync;
          state_d    = RELEASE;
        end else if (tmr_q == '0) begin
          wd_expire = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RELEASE: begin
        if (clk_sync && data_sync) begin
          done_d   = 1'b1;
          ack_ok_d = ack_seen_q;
          err_d    = 1'b0;
          state_d  = IDLE;
        end else if (tmr_q == '0) begin
          wd_expire = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wd_expire) begin
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      ack_ok_d  = 1'b0;
      err_d     = 1'b1;
      state_d   = IDLE;
    end
  end

  // Holding tx_ready low during the done cycle makes it rise the cycle after done.
  assign tx_ready    = (state_q == IDLE) && !done_q;
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, directed vector table and multi-cycle sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // Scaled timing keeps the run short; the device clock is far slower than edge-detect latency.
  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int HALF = 50;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  ps2_state_e state_dbg;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk_in = ~clk_in;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (100_000_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  // Length of the most recent host clock-inhibit pulse, in clk_in cycles.
  int inh_run = 0;
  int inh_last = 0;
  always @(negedge clk_in) begin
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  initial begin
    #800_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk_in);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock n_pulses bits, optionally ack on pulse 11.
  task automatic bfm_frame(input int n_pulses, input bit do_ack,
                           output logic [9:0] bits, output bit started);
    started = 1'b0;
    bits    = '0;
    for (int w = 0; w < INH + 300; w++) begin
      @(negedge clk_in);
      if (ps2_data_in == 1'b0 && ps2_clk_in == 1'b1) begin
        started = 1'b1;
        break;
      end
    end
    if (!started) return;
    repeat (HALF) @(negedge clk_in);
    for (int k = 1; k <= n_pulses && k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_in);
      dev_clk_low = 1'b0;
      bits[k-1] = ps2_data_in;
      repeat (HALF) @(negedge clk_in);
    end
    if (n_pulses >= 11) begin
      if (do_ack) dev_data_low = 1'b1;
      repeat (HALF / 2) @(negedge clk_in);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_in);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk_in);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic a, output logic e,
                           output logic rdy_at, output logic rdy_next, output logic oe_any);
    seen = 1'b0; a = 1'bx; e = 1'bx; rdy_at = 1'bx; rdy_next = 1'bx; oe_any = 1'bx;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_in);
      if (done) begin
        seen   = 1'b1;
        a      = ack_ok;
        e      = err;
        rdy_at = tx_ready;
        oe_any = ps2_clk_oe | ps2_data_oe;
        @(negedge clk_in);
        rdy_next = tx_ready;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         do_ack;
    logic       exp_par;
    logic       exp_ack;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [9:0] bits;
    bit started, seen;
    logic a, e, rdy_at, rdy_next, oe_any;
    exp_q.push_back(v.data);
    send(v.data);
    fork
      bfm_frame(11, v.do_ack, bits, started);
      wait_done(INH + 30 * HALF, seen, a, e, rdy_at, rdy_next, oe_any);
    join
    check({tag, " request"}, 32'(started), 32'd1);
    check({tag, " data"}, 32'(bits[7:0]), 32'(exp_q.pop_front()));
    check({tag, " parity"}, 32'(bits[8]), 32'(v.exp_par));
    check({tag, " stop"}, 32'(bits[9]), 32'd1);
    check({tag, " inhibit_len"}, 32'(inh_last), 32'(INH));
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " ack_ok"}, 32'(a), 32'(v.exp_ack));
    check({tag, " err"}, 32'(e), 32'd0);
    check({tag, " ready_at_done"}, 32'(rdy_at), 32'd0);
    check({tag, " ready_after_done"}, 32'(rdy_next), 32'd1);
    check({tag, " lines_released"}, 32'(oe_any), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    logic [9:0] b1, b2, b3;
    bit s1, s2, s3, seen, got_ready;
    int cnt;
    vecs[0] = '{data: 8'hF4, do_ack: 1'b1, exp_par: 1'b0, exp_ack: 1'b1};
    vecs[1] = '{data: 8'h00, do_ack: 1'b1, exp_par: 1'b1, exp_ack: 1'b1};
    vecs[2] = '{data: 8'hA5, do_ack: 1'b0, exp_par: 1'b1, exp_ack: 1'b0};
    vecs[3] = '{data: 8'hFF, do_ack: 1'b1, exp_par: 1'b1, exp_ack: 1'b1};
    vecs[4] = '{data: 8'h01, do_ack: 1'b1, exp_par: 1'b0, exp_ack: 1'b1};

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst tx_ready", 32'(tx_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ack_ok", 32'(ack_ok), 32'd0);
    check("rst err", 32'(err), 32'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Device never clocks: watchdog must abort the frame.
    send(8'h55);
    seen = 1'b0;
    for (int c = 0; c < INH + 50; c++) begin
      @(negedge clk_in);
      if (ps2_data_oe) begin
        seen = 1'b1;
        break;
      end
    end
    check("wd request", 32'(seen), 32'd1);
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < TMO + 100; c++) begin
      @(negedge clk_in);
      cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("wd done", 32'(seen), 32'd1);
    check("wd length", 32'(cnt >= TMO && cnt <= TMO + 2), 32'd1);
    check("wd err", 32'(err), 32'd1);
    check("wd ack_ok", 32'(ack_ok), 32'd0);
    check("wd oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
    @(negedge clk_in);
    check("wd ready_after", 32'(tx_ready), 32'd1);

    // tx_valid held during busy: second byte taken only once tx_ready returns.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hFF);
    got_ready = 1'b0;
    fork
      begin
        @(negedge clk_in);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_data = 8'hFF;
        for (int c = 0; c < INH + 30 * HALF; c++) begin
          @(negedge clk_in);
          if (tx_ready) begin
            got_ready = 1'b1;
            break;
          end
        end
        @(negedge clk_in);
        tx_valid = 1'b0;
      end
      begin
        bfm_frame(11, 1'b1, b1, s1);
        bfm_frame(11, 1'b1, b2, s2);
        bfm_frame(11, 1'b1, b3, s3);
      end
    join
    check("hold ready_seen", 32'(got_ready), 32'd1);
    check("hold frame1", 32'(b1[7:0]), 32'(exp_q.pop_front()));
    check("hold frame2", 32'(b2[7:0]), 32'(exp_q.pop_front()));
    check("hold parity2", 32'(b2[8]), 32'd1);
    check("hold frame_count", 32'(int'(s1) + int'(s2) + int'(s3)), 32'd2);

    // Asynchronous reset in the middle of the shift phase.
    send(8'hF4);
    bfm_frame(4, 1'b0, b1, s1);
    check("arst request", 32'(s1), 32'd1);
    check("arst bits", 32'(b1[3:0]), 32'h4);
    check("arst pre_busy", 32'(busy), 32'd1);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check("arst clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("arst data_oe", 32'(ps2_data_oe), 32'd0);
    check("arst state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("arst tx_ready", 32'(tx_ready), 32'd1);
    check("arst busy", 32'(busy), 32'd0);
    run_vec('{data: 8'h3C, do_ack: 1'b1, exp_par: 1'b1, exp_ack: 1'b1}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
